prbs_gen_chk: RTL and testbench
===============================

Name: prbs_gen_chk

Overview:
- Parametrised PRBS generator and checker pair for the test-pattern path.
- Generator emits a seed word n_pattern times, then a free-running word-wide LFSR sequence.
- Checker hunts for n_pattern consecutive seed words, locks, then tracks the PRBS sequence, counting bit-word errors and declaring loss of lock.
- Replaces the fixed 8-bit generator/detector pair. Adds width/tap parametrisation, a start/stop handshake, error counting and lock-loss recovery.

Parameters:
WIDTH, 8, word and LFSR width (>=4)
TAPS, 8'hB8, Fibonacci feedback mask, WIDTH bits; bit i set = lfsr[i] in XOR feedback
CNT_W, 8, width of n_pattern and run counters
ERR_W, 16, width of saturating error counter
LOSS_THRESH, 4, consecutive mismatches in TRACK that drop lock

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, starts generator (ignored unless gen IDLE)
stop  in  1  one-cycle pulse, returns generator to IDLE (priority over start)
seed  in  WIDTH  pattern word and LFSR seed; sampled on start
n_pattern  in  CNT_W  pattern repeat count (gen and chk); sampled on start / on HUNT entry
gen_out  out  WIDTH  generated word
gen_valid  out  1  gen_out valid
chk_in  in  WIDTH  word under check
chk_valid  in  1  chk_in valid
pattern_found  out  1  level, high while checker in TRACK
lock_lost  out  1  one-cycle pulse on TRACK->HUNT
err_cnt  out  ERR_W  saturating mismatch count since last lock
clr_err  in  1  synchronous clear of err_cnt

Behaviour:
- Reset (RST=0, async): gen state IDLE, chk state HUNT, gen_out=0, gen_valid=0, pattern_found=0, lock_lost=0, err_cnt=0, all counters 0.
- LFSR step: fb = ^(s & TAPS); next = {s[WIDTH-2:0], fb}. All-zero state is forbidden: a zero seed is replaced by all-ones for the LFSR (pattern phase still outputs 0).
- Generator FSM, all outputs registered:
  - IDLE: gen_valid=0. On start: latch seed and n_pattern, cnt=0. Next state is PATTERN, or PRBS directly if n_pattern=0.
  - PATTERN: gen_out=seed_q, gen_valid=1, cnt++. When cnt==n_pattern-1, next state is PRBS with lfsr=seed_q (or all-ones).
  - PRBS: gen_out=lfsr, gen_valid=1, lfsr steps every cycle; runs until stop.
  - Latency: first valid word appears the cycle after start.
  - stop in any state -> IDLE next cycle, gen_valid=0.
  - start while busy is ignored. start and stop in the same cycle -> stop wins.
- Checker FSM; it advances only on chk_valid=1 cycles, and invalid cycles hold all state:
  - HUNT: run counter. chk_in==seed -> run++, else run=0. On the valid word where run reaches max(n_pattern,1): next state TRACK, expected=seed (zero-substituted), pattern_found=1 the following cycle, err_cnt=0, miss=0.
  - TRACK: compare chk_in vs expected, then expected steps.
    - Mismatch: err_cnt++ (saturating at all-ones), miss++.
    - Match: miss=0.
    - miss reaching LOSS_THRESH: next state HUNT, run=0, pattern_found=0, lock_lost pulse one cycle. err_cnt holds its value.
- clr_err: err_cnt=0 next cycle. If clr_err coincides with an increment, clear wins.
- seed/n_pattern changes mid-operation: the generator uses latched values. The checker reads live seed in HUNT and latches it on TRACK entry.
- Generator and checker are independent; loopback gen_out->chk_in (gen_valid->chk_valid) locks with zero errors.

Decomposition:
- Package prbs_pkg holds:
  - gen_state_t {IDLE, PATTERN, PRBS}
  - chk_state_t {HUNT, TRACK}
  - default TAPS constant
  - function lfsr_next(s, taps)
- Sub-module prbs_lfsr: WIDTH-wide register with load/seed/step enable and zero-seed substitution. Instantiated once in the generator and once as the checker expected-value register.

Test Plan:
- Reset values: RST low mid-PRBS -> all outputs 0 immediately, gen IDLE.
- Generator sequence: seed=8'h01, n_pattern=3, start -> gen_out 01,01,01 then 01,02,04,08,11, gen_valid high from the cycle after start.
- Loopback lock: same stimulus looped to checker -> pattern_found rises the cycle after the 3rd 01; err_cnt stays 0 over 300 words.
- Error injection: flip one bit of each of 2 isolated words in TRACK -> err_cnt=2, lock held. Corrupt 4 consecutive words -> lock_lost pulse, pattern_found=0, then HUNT re-locks on a fresh start.
- Corner cases:
  - n_pattern=0 -> generator goes straight to PRBS; checker locks after 1 seed word.
  - seed=0 -> PRBS begins FF,FE,...
  - start+stop in the same cycle -> stays IDLE.
- Saturation: ERR_W=4 with continuous mismatches and LOSS_THRESH large -> err_cnt sticks at 15. clr_err -> 0 the next cycle.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types and LFSR helpers for the PRBS generator/checker pair.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PATTERN,
    PRBS
  } gen_state_t;

  typedef enum logic {
    HUNT,
    TRACK
  } chk_state_t;

  localparam logic [7:0] DEF_TAPS = 8'hB8;

  // Fibonacci step on the low w bits: shift left, feedback into bit 0.
  function automatic logic [63:0] lfsr_next(
    input logic [63:0] s,
    input logic [63:0] taps,
    input int          w
  );
    logic [63:0] m;
    logic        fb;
    m  = (64'd1 << w) - 64'd1;
    fb = ^(s & taps & m);
    return ((s << 1) | {63'd0, fb}) & m;
  endfunction

  // An all-zero LFSR state locks up, so zero seeds become all-ones.
  function automatic logic [63:0] nz_seed(
    input logic [63:0] s,
    input int          w
  );
    return (s == 64'd0) ? ((64'd1 << w) - 64'd1) : s;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Word-wide Fibonacci LFSR register with load and step enables.
import prbs_pkg::*;

module prbs_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] fix;
  logic [WIDTH-1:0] nxt;

  assign fix = WIDTH'(nz_seed(64'(seed_i), WIDTH));
  assign nxt = WIDTH'(lfsr_next(64'(q_q), 64'(TAPS), WIDTH));

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = fix;
    end else if (step_i) begin
      q_d = nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS pattern generator and locking checker with error counting.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEF_TAPS),
  parameter int               CNT_W       = 8,
  parameter int               ERR_W       = 16,
  parameter int               LOSS_THRESH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] n_pattern,
  output logic [WIDTH-1:0] gen_out,
  output logic             gen_valid,
  input  logic [WIDTH-1:0] chk_in,
  input  logic             chk_valid,
  output logic             pattern_found,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             clr_err
);

  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [MISS_W:0] LT = (MISS_W + 1)'(LOSS_THRESH);

  gen_state_t       gst_q;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] gout_q;
  logic             gvld_q;
  logic [WIDTH-1:0] g_lq;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] g_lseed;
  logic             g_fire;
  logic             g_last;
  logic             g_enter;
  logic             g_step;

  assign g_fire  = start && !stop && (gst_q == IDLE);
  assign g_last  = (gst_q == PATTERN) && (cnt_q == n_q - CNT_W'(1));
  assign g_enter = !stop && ((g_fire && n_pattern == '0) || g_last);
  assign g_step  = !stop && (gst_q == PRBS);
  assign g_lseed = (gst_q == IDLE) ? seed : seed_q;
  assign g_nxt   = WIDTH'(lfsr_next(64'(g_lq), 64'(TAPS), WIDTH));

  prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_gen_lfsr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (g_enter),
    .step_i (g_step),
    .seed_i (g_lseed),
    .q_o    (g_lq)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gst_q  <= IDLE;
      seed_q <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
      gout_q <= '0;
      gvld_q <= 1'b0;
    end else if (stop) begin
      gst_q  <= IDLE;
      gout_q <= '0;
      gvld_q <= 1'b0;
    end else begin
      unique case (gst_q)
        IDLE: begin
          if (start) begin
            seed_q <= seed;
            n_q    <= n_pattern;
            cnt_q  <= '0;
            gvld_q <= 1'b1;
            if (n_pattern == '0) begin
              gst_q  <= PRBS;
              gout_q <= WIDTH'(nz_seed(64'(seed), WIDTH));
            end else begin
              gst_q  <= PATTERN;
              gout_q <= seed;
            end
          end
        end
        PATTERN: begin
          if (g_last) begin
            gst_q  <= PRBS;
            gout_q <= WIDTH'(nz_seed(64'(seed_q), WIDTH));
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRBS: begin
          gout_q <= g_nxt;
        end
        default: begin
          gst_q  <= IDLE;
          gvld_q <= 1'b0;
        end
      endcase
    end
  end

  assign gen_out   = gout_q;
  assign gen_valid = gvld_q;

  chk_state_t       cst_q;
  logic [CNT_W-1:0] run_q;
  logic [MISS_W-1:0] miss_q;
  logic [ERR_W-1:0] err_q;
  logic             pf_q;
  logic             ll_q;
  logic [WIDTH-1:0] e_q;
  logic [CNT_W:0]   run_inc;
  logic [CNT_W:0]   need;
  logic [MISS_W:0]  miss_inc;
  logic             hit;
  logic             c_lock;
  logic             c_trk;
  logic             c_miss;
  logic             c_drop;

  assign hit      = (chk_in == seed);
  assign run_inc  = {1'b0, run_q} + (CNT_W + 1)'(1);
  assign need     = (n_pattern == '0) ? (CNT_W + 1)'(1) : {1'b0, n_pattern};
  assign c_lock   = chk_valid && (cst_q == HUNT) && hit && (run_inc >= need);
  assign c_trk    = chk_valid && (cst_q == TRACK);
  assign c_miss   = c_trk && (chk_in != e_q);
  assign miss_inc = {1'b0, miss_q} + (MISS_W + 1)'(1);
  assign c_drop   = c_miss && (miss_inc >= LT);

  // Expected-value register: seeded from live seed on lock, steps per tracked word.
  prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_exp_lfsr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (c_lock),
    .step_i (c_trk),
    .seed_i (seed),
    .q_o    (e_q)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cst_q  <= HUNT;
      run_q  <= '0;
      miss_q <= '0;
      err_q  <= '0;
      pf_q   <= 1'b0;
      ll_q   <= 1'b0;
    end else begin
      ll_q <= 1'b0;
      if (clr_err || c_lock) begin
        err_q <= '0;
      end else if (c_miss && !(&err_q)) begin
        err_q <= err_q + ERR_W'(1);
      end
      if (chk_valid) begin
        unique case (cst_q)
          HUNT: begin
            if (c_lock) begin
              cst_q  <= TRACK;
              pf_q   <= 1'b1;
              miss_q <= '0;
              run_q  <= '0;
            end else begin
              run_q <= hit ? run_inc[CNT_W-1:0] : '0;
            end
          end
          TRACK: begin
            if (c_drop) begin
              cst_q  <= HUNT;
              run_q  <= '0;
              miss_q <= '0;
              pf_q   <= 1'b0;
              ll_q   <= 1'b1;
            end else if (c_miss) begin
              miss_q <= miss_inc[MISS_W-1:0];
            end else begin
              miss_q <= '0;
            end
          end
          default: cst_q <= HUNT;
        endcase
      end
    end
  end

  assign pattern_found = pf_q;
  assign lock_lost     = ll_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: loopback, error injection, corners, saturation.
module tb_prbs_gen_chk;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        stop;
  logic [7:0]  seed;
  logic [7:0]  n_pattern;
  logic [7:0]  gen_out;
  logic        gen_valid;
  logic [7:0]  chk_in;
  logic        chk_valid;
  logic        pf;
  logic        ll;
  logic [15:0] err;
  logic        clr_err;
  logic [7:0]  flip;

  logic        s_start;
  logic        s_stop;
  logic [7:0]  s_seed;
  logic [7:0]  s_n;
  logic [7:0]  s_gen_out;
  logic        s_gen_valid;
  logic [7:0]  s_chk_in;
  logic        s_chk_valid;
  logic        s_pf;
  logic        s_ll;
  logic [3:0]  s_err;
  logic        s_clr;

  int tests;
  int fails;

  assign chk_in    = gen_out ^ flip;
  assign chk_valid = gen_valid;

  prbs_gen_chk u_dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .stop          (stop),
    .seed          (seed),
    .n_pattern     (n_pattern),
    .gen_out       (gen_out),
    .gen_valid     (gen_valid),
    .chk_in        (chk_in),
    .chk_valid     (chk_valid),
    .pattern_found (pf),
    .lock_lost     (ll),
    .err_cnt       (err),
    .clr_err       (clr_err)
  );

  prbs_gen_chk #(
    .ERR_W       (4),
    .LOSS_THRESH (200)
  ) u_sat (
    .CLK           (CLK),
    .RST           (RST),
    .start         (s_start),
    .stop          (s_stop),
    .seed          (s_seed),
    .n_pattern     (s_n),
    .gen_out       (s_gen_out),
    .gen_valid     (s_gen_valid),
    .chk_in        (s_chk_in),
    .chk_valid     (s_chk_valid),
    .pattern_found (s_pf),
    .lock_lost     (s_ll),
    .err_cnt       (s_err),
    .clr_err       (s_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic       st;
    logic       sp;
    logic [7:0] out;
    logic       vld;
    logic       pf;
  } vec_t;

  vec_t tv [12];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  initial begin
    logic [7:0] seq0 [5];
    int nll;
    bit got;

    tests = 0;
    fails = 0;
    RST = 1'b0;
    start = 0; stop = 0; seed = 8'h01; n_pattern = 8'd3;
    clr_err = 0; flip = 8'h00;
    s_start = 0; s_stop = 0; s_seed = 8'h5A; s_n = 8'd1;
    s_chk_in = 8'h00; s_chk_valid = 0; s_clr = 0;

    tv[0]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 8'h01, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 8'h02, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 1'b0, 8'h04, 1'b1, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 8'h08, 1'b1, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 8'h23, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    seq0[0] = 8'h00; seq0[1] = 8'h00; seq0[2] = 8'hFF;
    seq0[3] = 8'hFE; seq0[4] = 8'hFC;

    repeat (2) @(posedge CLK);
    #1;
    check("rst gen_out", 32'(gen_out), 32'h0);
    check("rst gen_valid", 32'(gen_valid), 32'h0);
    check("rst pattern_found", 32'(pf), 32'h0);
    check("rst lock_lost", 32'(ll), 32'h0);
    check("rst err_cnt", 32'(err), 32'h0);
    RST = 1'b1;

    // Table: generator sequence with loopback lock
    for (int i = 0; i < 12; i++) begin
      start = tv[i].st;
      stop  = tv[i].sp;
      tick();
      start = 0;
      stop  = 0;
      check($sformatf("vec%0d gen_out", i), 32'(gen_out), 32'(tv[i].out));
      check($sformatf("vec%0d gen_valid", i), 32'(gen_valid), 32'(tv[i].vld));
      check($sformatf("vec%0d pattern_found", i), 32'(pf), 32'(tv[i].pf));
    end
    check("table err_cnt", 32'(err), 32'h0);

    // Long loopback
    reset_dut();
    seed = 8'h01; n_pattern = 8'd3;
    start = 1; tick(); start = 0;
    nll = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ll) nll++;
    end
    check("loop pattern_found", 32'(pf), 32'h1);
    check("loop err_cnt", 32'(err), 32'h0);
    check("loop lock_lost count", 32'(nll), 32'h0);

    // Two isolated errors
    flip = 8'h01; tick(); flip = 8'h00;
    repeat (5) tick();
    flip = 8'h80; tick(); flip = 8'h00;
    repeat (5) tick();
    check("iso err_cnt", 32'(err), 32'h2);
    check("iso pattern_found", 32'(pf), 32'h1);

    // Four consecutive errors drop lock
    flip = 8'h10;
    repeat (3) tick();
    check("3 miss pattern_found", 32'(pf), 32'h1);
    check("3 miss lock_lost", 32'(ll), 32'h0);
    tick();
    flip = 8'h00;
    check("4 miss lock_lost", 32'(ll), 32'h1);
    check("4 miss pattern_found", 32'(pf), 32'h0);
    check("4 miss err_cnt", 32'(err), 32'h6);
    tick();
    check("lock_lost pulse end", 32'(ll), 32'h0);
    check("err hold after loss", 32'(err), 32'h6);

    // Relock on a fresh start
    stop = 1; tick(); stop = 0;
    start = 1; tick(); start = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (pf) begin
        got = 1;
        break;
      end
      tick();
    end
    check("relock pattern_found", 32'(got), 32'h1);
    check("relock err_cnt zeroed", 32'(err), 32'h0);

    flip = 8'h04; tick(); flip = 8'h00;
    tick();
    check("post relock err", 32'(err), 32'h1);
    clr_err = 1; tick(); clr_err = 0;
    check("clr_err", 32'(err), 32'h0);

    // Async reset mid-PRBS
    flip = 8'h02; tick(); flip = 8'h00;
    #2;
    RST = 1'b0;
    #1;
    check("async gen_out", 32'(gen_out), 32'h0);
    check("async gen_valid", 32'(gen_valid), 32'h0);
    check("async pattern_found", 32'(pf), 32'h0);
    check("async err_cnt", 32'(err), 32'h0);
    tick();
    RST = 1'b1;

    // n_pattern = 0
    seed = 8'h01; n_pattern = 8'd0;
    start = 1; tick(); start = 0;
    check("n0 gen_out0", 32'(gen_out), 32'h01);
    check("n0 gen_valid", 32'(gen_valid), 32'h1);
    check("n0 pf before", 32'(pf), 32'h0);
    tick();
    check("n0 gen_out1", 32'(gen_out), 32'h02);
    check("n0 pf lock", 32'(pf), 32'h1);

    // Zero seed
    reset_dut();
    seed = 8'h00; n_pattern = 8'd2;
    start = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 0;
      check($sformatf("seed0 word%0d", i), 32'(gen_out), 32'(seq0[i]));
    end
    check("seed0 pattern_found", 32'(pf), 32'h1);
    check("seed0 err_cnt", 32'(err), 32'h0);

    // Saturating counter on the narrow instance
    reset_dut();
    s_seed = 8'h5A; s_n = 8'd1;
    s_chk_in = 8'h5A; s_chk_valid = 1;
    tick();
    check("sat lock", 32'(s_pf), 32'h1);
    s_chk_in = 8'h00;
    repeat (3) tick();
    check("sat err3", 32'(s_err), 32'h3);
    s_chk_valid = 0;
    repeat (2) tick();
    check("sat hold invalid", 32'(s_err), 32'h3);
    s_chk_valid = 1;
    repeat (20) tick();
    check("sat err stuck", 32'(s_err), 32'hF);
    check("sat still locked", 32'(s_pf), 32'h1);
    s_clr = 1; tick(); s_clr = 0;
    check("sat clr wins", 32'(s_err), 32'h0);
    tick();
    check("sat count after clr", 32'(s_err), 32'h1);
    check("sat gen idle", 32'({s_gen_valid, s_gen_out}), 32'h0);
    check("sat no lock_lost", 32'(s_ll), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
